// File: rtl/trap_sequencer_if.sv
// ----------------------------------------------------------------------------
// trap_sequencer_if
// Purpose : Bundles the Execute-stage control, interrupt and CSR-file signals
//           that connect the trap sequencer to the rest of the pipeline.
// Modports:
//   master - the trap sequencer: receives interrupt/CSR/Execute status and
//            drives pc_sel, flush/kill/stall, trap_req, mepc_o, mcause_o,
//            mret_ack and in_trap.
//   slave  - the surrounding pipeline and CSR file: the opposite direction.
// ----------------------------------------------------------------------------
interface trap_sequencer_if #(
    parameter int XLEN = 32
);
    logic            irq_ext;
    logic            irq_timer;
    logic            mstatus_mie;
    logic            mie_meie;
    logic            mie_mtie;
    logic            valid_E;
    logic [XLEN-1:0] PC_E;
    logic            br_taken_E;
    logic            is_mret_E;
    logic            illegal_E;
    logic            ecall_E;
    logic [1:0]      pc_sel;
    logic            flush_D;
    logic            kill_E;
    logic            stall_F;
    logic            trap_req;
    logic [XLEN-1:0] mepc_o;
    logic [XLEN-1:0] mcause_o;
    logic            mret_ack;
    logic            in_trap;

    modport master (
        input  irq_ext, irq_timer, mstatus_mie, mie_meie, mie_mtie,
        input  valid_E, PC_E, br_taken_E, is_mret_E, illegal_E, ecall_E,
        output pc_sel, flush_D, kill_E, stall_F, trap_req,
        output mepc_o, mcause_o, mret_ack, in_trap
    );

    modport slave (
        output irq_ext, irq_timer, mstatus_mie, mie_meie, mie_mtie,
        output valid_E, PC_E, br_taken_E, is_mret_E, illegal_E, ecall_E,
        input  pc_sel, flush_D, kill_E, stall_F, trap_req,
        input  mepc_o, mcause_o, mret_ack, in_trap
    );
endinterface

// File: rtl/trap_sequencer.sv
// ----------------------------------------------------------------------------
// trap_sequencer
// Purpose : PC-select control for the 3-stage pipeline. Steers fetch between
//           PC+4 (00), the ALU branch target (01) and the CSR epc/vector (10),
//           and sequences exceptions, interrupts and mret: kill Execute, flush
//           Decode, hand mepc/mcause to the CSR file, then redirect fetch.
// Ports   :
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - trap_sequencer_if.master (Execute status, interrupt lines, CSR
//          enables in; pc_sel, flush/kill/stall, trap_req, mepc_o, mcause_o,
//          mret_ack, in_trap out)
// ----------------------------------------------------------------------------
module trap_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int XLEN        = 32
) (
    input logic              clk,
    input logic              rst,
    trap_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SAVE     = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(2);
    localparam logic [XLEN-1:0] CAUSE_ECALL   = XLEN'(11);
    localparam logic [XLEN-1:0] CAUSE_EXT     = {1'b1, (XLEN-1)'(11)};
    localparam logic [XLEN-1:0] CAUSE_TIMER   = {1'b1, (XLEN-1)'(7)};

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_irq_sync;
    logic                   r_in_trap;
    logic                   r_trap_req;
    logic [XLEN-1:0]        r_mepc;
    logic [XLEN-1:0]        r_mcause;

    logic                   w_irq_ext_s;
    logic                   w_ext_p;
    logic                   w_tmr_p;
    logic                   w_exc;
    logic                   w_intr;
    logic                   w_take;
    logic                   w_mret;
    logic [XLEN-1:0]        w_cause;
    logic [1:0]             w_pc_sel;
    logic                   w_flush_D;
    logic                   w_kill_E;
    logic                   w_stall_F;
    logic                   w_mret_ack;

    assign w_irq_ext_s = r_irq_sync[SYNC_STAGES-1];
    assign w_ext_p     = w_irq_ext_s & bus.mie_meie & bus.mstatus_mie & ~r_in_trap;
    assign w_tmr_p     = bus.irq_timer & bus.mie_mtie & bus.mstatus_mie & ~r_in_trap;
    assign w_exc       = bus.valid_E & (bus.illegal_E | bus.ecall_E);
    // An mret cycle never takes an interrupt, so in_trap is already clear
    // before the next pending interrupt can be accepted.
    assign w_intr      = bus.valid_E & ~w_exc & ~bus.is_mret_E & (w_ext_p | w_tmr_p);
    assign w_take      = w_exc | w_intr;
    assign w_mret      = bus.valid_E & bus.is_mret_E & ~w_exc;

    // Cause priority: exception (illegal before ecall) > external > timer.
    always_comb begin
        w_cause = CAUSE_TIMER;
        if (w_exc) begin
            w_cause = bus.illegal_E ? CAUSE_ILLEGAL : CAUSE_ECALL;
        end else if (w_ext_p) begin
            w_cause = CAUSE_EXT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= RUN;
            r_irq_sync <= '0;
            r_in_trap  <= 1'b0;
            r_trap_req <= 1'b0;
            r_mepc     <= '0;
            r_mcause   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_irq_sync <= {r_irq_sync[SYNC_STAGES-2:0], bus.irq_ext};
            // trap_req is high exactly while the FSM sits in SAVE.
            r_trap_req <= (r_state == RUN) && w_take;
            if ((r_state == RUN) && w_take) begin
                r_mepc   <= bus.PC_E;
                r_mcause <= w_cause;
            end
            if (r_state == SAVE) begin
                r_in_trap <= 1'b1;
            end else if ((r_state == RUN) && w_mret) begin
                r_in_trap <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_sel    = 2'b00;
        w_flush_D   = 1'b0;
        w_kill_E    = 1'b0;
        w_stall_F   = 1'b0;
        w_mret_ack  = 1'b0;
        // Outputs held quiet while reset is asserted, whatever Execute shows.
        if (rst) begin
            case (r_state)
                RUN: begin
                    if (w_take) begin
                        // Trap wins over any taken branch in the same cycle.
                        w_kill_E    = 1'b1;
                        w_flush_D   = 1'b1;
                        w_stall_F   = 1'b1;
                        w_state_nxt = SAVE;
                    end else if (w_mret) begin
                        w_pc_sel   = 2'b10;
                        w_flush_D  = 1'b1;
                        w_mret_ack = 1'b1;
                    end else begin
                        w_pc_sel  = {1'b0, bus.br_taken_E & bus.valid_E};
                        w_flush_D = bus.br_taken_E & bus.valid_E;
                    end
                end
                SAVE: begin
                    w_stall_F   = 1'b1;
                    w_flush_D   = 1'b1;
                    w_kill_E    = 1'b1;
                    w_state_nxt = REDIRECT;
                end
                REDIRECT: begin
                    // CSR file now presents mtvec on epc.
                    w_pc_sel    = 2'b10;
                    w_flush_D   = 1'b1;
                    w_kill_E    = 1'b1;
                    w_state_nxt = RUN;
                end
                default: begin
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

    assign bus.pc_sel   = w_pc_sel;
    assign bus.flush_D  = w_flush_D;
    assign bus.kill_E   = w_kill_E;
    assign bus.stall_F  = w_stall_F;
    assign bus.mret_ack = w_mret_ack;
    assign bus.trap_req = r_trap_req;
    assign bus.mepc_o   = r_mepc;
    assign bus.mcause_o = r_mcause;
    assign bus.in_trap  = r_in_trap;
endmodule

// File: tb/tb_trap_sequencer.sv
module tb_trap_sequencer;
    localparam int XLEN = 32;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    trap_sequencer_if #(.XLEN(XLEN)) tif ();

    trap_sequencer #(.SYNC_STAGES(2), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (tif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        v, br, mret, ill, ecall;
        logic [31:0] pc;
        logic [1:0]  sel;
        logic        flush, kill, stall, ack, trap;
        logic [31:0] cause;
        logic        it_after;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input logic v, br, mret, ill, ecall,
                                input logic [31:0] pc, input logic [1:0] sel,
                                input logic flush, kill, stall, ack, trap,
                                input logic [31:0] cause, input logic it_after);
        vec_t r;
        r.v = v; r.br = br; r.mret = mret; r.ill = ill; r.ecall = ecall;
        r.pc = pc; r.sel = sel; r.flush = flush; r.kill = kill;
        r.stall = stall; r.ack = ack; r.trap = trap; r.cause = cause;
        r.it_after = it_after;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, br, mret, ill, ecall, input logic [31:0] pc);
        tif.valid_E    = v;
        tif.br_taken_E = br;
        tif.is_mret_E  = mret;
        tif.illegal_E  = ill;
        tif.ecall_E    = ecall;
        tif.PC_E       = pc;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        int pulses;
        int redirects;
        n_chk = 0;
        n_err = 0;
        rst   = 1'b0;
        tif.irq_ext     = 1'b0;
        tif.irq_timer   = 1'b0;
        tif.mstatus_mie = 1'b0;
        tif.mie_meie    = 1'b0;
        tif.mie_mtie    = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10);

        //          v  br mret ill ecall pc          sel  fl k  s  ack trap cause        it
        tbl[0]  = mk(0, 1, 0, 0, 0, 32'h0000_0010, 2'b00, 0, 0, 0, 0, 0, 32'd0,  0);
        tbl[1]  = mk(1, 1, 0, 0, 0, 32'h0000_0014, 2'b01, 1, 0, 0, 0, 0, 32'd0,  0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 32'h0000_0018, 2'b00, 0, 0, 0, 0, 0, 32'd0,  0);
        tbl[3]  = mk(1, 1, 0, 1, 0, 32'h0000_0040, 2'b00, 1, 1, 1, 0, 1, 32'd2,  1);
        tbl[4]  = mk(1, 1, 0, 0, 0, 32'h0000_0020, 2'b01, 1, 0, 0, 0, 0, 32'd0,  1);
        tbl[5]  = mk(1, 0, 1, 0, 0, 32'h0000_0024, 2'b10, 1, 0, 0, 1, 0, 32'd0,  0);
        tbl[6]  = mk(1, 0, 0, 0, 1, 32'h0000_0080, 2'b00, 1, 1, 1, 0, 1, 32'd11, 1);
        tbl[7]  = mk(1, 0, 0, 0, 1, 32'h0000_0084, 2'b00, 1, 1, 1, 0, 1, 32'd11, 1);
        tbl[8]  = mk(1, 1, 1, 0, 0, 32'h0000_0088, 2'b10, 1, 0, 0, 1, 0, 32'd0,  0);
        tbl[9]  = mk(0, 0, 1, 0, 0, 32'h0000_008C, 2'b00, 0, 0, 0, 0, 0, 32'd0,  0);
        tbl[10] = mk(0, 0, 0, 1, 0, 32'h0000_0090, 2'b00, 0, 0, 0, 0, 0, 32'd0,  0);
        tbl[11] = mk(1, 1, 1, 1, 1, 32'h0000_0200, 2'b00, 1, 1, 1, 0, 1, 32'd2,  1);
        tbl[12] = mk(1, 0, 1, 0, 0, 32'h0000_0204, 2'b10, 1, 0, 0, 1, 0, 32'd0,  0);

        // Reset state, with a taken branch presented on Execute.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc_sel",   tif.pc_sel,   2'b00);
        chk("rst_flush",    tif.flush_D,  1'b0);
        chk("rst_trap_req", tif.trap_req, 1'b0);
        chk("rst_mcause",   tif.mcause_o, 32'h0);
        chk("rst_in_trap",  tif.in_trap,  1'b0);
        idle();
        #2 rst = 1'b1;
        tick();

        // Table-driven vectors, interrupts disabled.
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].br, tbl[i].mret, tbl[i].ill, tbl[i].ecall, tbl[i].pc);
            #1;
            chk($sformatf("v%0d_pc_sel", i),   tif.pc_sel,   tbl[i].sel);
            chk($sformatf("v%0d_flush", i),    tif.flush_D,  tbl[i].flush);
            chk($sformatf("v%0d_kill", i),     tif.kill_E,   tbl[i].kill);
            chk($sformatf("v%0d_stall", i),    tif.stall_F,  tbl[i].stall);
            chk($sformatf("v%0d_mret_ack", i), tif.mret_ack, tbl[i].ack);
            tick();
            if (tbl[i].trap) begin
                chk($sformatf("v%0d_trap_req", i),  tif.trap_req, 1'b1);
                chk($sformatf("v%0d_mepc", i),      tif.mepc_o,   tbl[i].pc);
                chk($sformatf("v%0d_mcause", i),    tif.mcause_o, tbl[i].cause);
                chk($sformatf("v%0d_save_kill", i), tif.kill_E,   1'b1);
                chk($sformatf("v%0d_save_stall", i), tif.stall_F, 1'b1);
                idle();
                tick();
                chk($sformatf("v%0d_redir_sel", i), tif.pc_sel,   2'b10);
                chk($sformatf("v%0d_redir_req", i), tif.trap_req, 1'b0);
                chk($sformatf("v%0d_redir_it", i),  tif.in_trap,  1'b1);
                tick();
            end
            chk($sformatf("v%0d_in_trap", i), tif.in_trap, tbl[i].it_after);
        end

        // Reset asserted mid-SAVE aborts the trap.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80);
        tick();
        chk("rs_trap_req_save", tif.trap_req, 1'b1);
        idle();
        #2 rst = 1'b0;
        #1;
        chk("rs_trap_req", tif.trap_req, 1'b0);
        chk("rs_mepc",     tif.mepc_o,   32'h0);
        chk("rs_mcause",   tif.mcause_o, 32'h0);
        chk("rs_in_trap",  tif.in_trap,  1'b0);
        chk("rs_outs",     {tif.pc_sel, tif.flush_D, tif.kill_E, tif.stall_F, tif.mret_ack}, 6'b0);
        #1 rst = 1'b1;
        pulses = 0;
        redirects = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (tif.trap_req) pulses++;
            if (tif.pc_sel == 2'b10) redirects++;
        end
        chk("rs_no_pulse",    pulses,    0);
        chk("rs_no_redirect", redirects, 0);

        // Timer pending but globally masked for 20 cycles.
        tif.mie_mtie  = 1'b1;
        tif.irq_timer = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000 + 32'(i * 4));
            tick();
            if (tif.trap_req || tif.kill_E) pulses++;
        end
        chk("tm_masked", pulses, 0);
        tif.mstatus_mie = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h300);
        #1;
        chk("tm_kill", tif.kill_E, 1'b1);
        tick();
        chk("tm_trap_req", tif.trap_req, 1'b1);
        chk("tm_mcause",   tif.mcause_o, 32'h8000_0007);
        chk("tm_mepc",     tif.mepc_o,   32'h300);
        idle();
        tick();
        tick();
        chk("tm_in_trap", tif.in_trap, 1'b1);

        // mret in handler with timer still pending.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h400);
        #1;
        chk("mr_pc_sel", tif.pc_sel,   2'b10);
        chk("mr_ack",    tif.mret_ack, 1'b1);
        chk("mr_flush",  tif.flush_D,  1'b1);
        chk("mr_kill",   tif.kill_E,   1'b0);
        tick();
        chk("mr_in_trap", tif.in_trap,  1'b0);
        chk("mr_no_req",  tif.trap_req, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h404);
        #1;
        chk("mr_tm_kill", tif.kill_E, 1'b1);
        tick();
        chk("mr_tm_req",    tif.trap_req, 1'b1);
        chk("mr_tm_mcause", tif.mcause_o, 32'h8000_0007);
        chk("mr_tm_mepc",   tif.mepc_o,   32'h404);
        idle();
        tick();
        tick();
        tif.irq_timer = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h500);
        tick();
        idle();
        chk("cl_in_trap", tif.in_trap, 1'b0);

        // External and timer together: external wins after synchronisation.
        tif.mie_meie  = 1'b1;
        tif.irq_ext   = 1'b1;
        tif.irq_timer = 1'b1;
        tick();
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100);
        #1;
        chk("ex_kill", tif.kill_E, 1'b1);
        tick();
        chk("ex_trap_req", tif.trap_req, 1'b1);
        chk("ex_mcause",   tif.mcause_o, 32'h8000_000B);
        chk("ex_mepc",     tif.mepc_o,   32'h100);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104 + 32'(i * 4));
            tick();
            if (tif.trap_req) pulses++;
        end
        chk("ex_masked_pulses", pulses, 0);
        chk("ex_mcause_hold",   tif.mcause_o, 32'h8000_000B);
        chk("ex_in_trap",       tif.in_trap,  1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
